mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one external memory request port between the CPU instruction-fetch side (I) and data side (D).
- Arbitrates each cycle, forwards the winning request, and tracks up to MAX_OUTSTANDING in-flight accesses in a source-tag FIFO.
- Routes each in-order response back to its requester.
- Sits between the CPU core's IMEM/DMEM interfaces and a single-port memory or bus.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; a power of two, ≥1.
- DATA_PRIORITY, 0, 0 = round-robin on contention; 1 = D always wins on contention.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request
- i_addr  in  32  instruction address
- i_gnt  out  1  I request accepted this cycle
- i_rvalid  out  1  I response valid
- i_rdata  out  32  I response data
- d_req  in  1  data request
- d_addr  in  32  data address
- d_wrdata  in  32  store data
- d_wrstb  in  4  byte write strobes; 0 = read
- d_gnt  out  1  D request accepted this cycle
- d_rvalid  out  1  D response valid (reads and writes)
- d_rdata  out  32  D response data
- m_req  out  1  memory request
- m_addr  out  32  memory address
- m_wrdata  out  32  memory store data
- m_wrstb  out  4  memory write strobes
- m_gnt  in  1  memory accepts request (handshake = m_req & m_gnt)
- m_rvalid  in  1  memory response, strictly in request order, exactly one per accepted request
- m_rdata  in  32  memory response data
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): outstanding count = 0, FIFO empty, last_grant = SRC_D (so the first tie goes to I), err = 0. All outputs 0 except passthrough data buses, which are don't-care while their valid is low.
- Full = (count == MAX_OUTSTANDING), evaluated on the registered count. When full, m_req = 0 and both gnt = 0, even if m_rvalid retires an entry that same cycle. There is no bypass.
- Selection is combinational in the same cycle, with no added latency:
  - Only one requester active: that one is selected.
  - Both active, DATA_PRIORITY=1: D is selected.
  - Both active, DATA_PRIORITY=0: the source opposite to last_grant is selected.
- m_req = (i_req | d_req) & !full.
- m_addr, m_wrdata and m_wrstb mux from the selected source. An I request drives m_wrstb = 0 and m_wrdata = 0.
- Grant to the selected source = m_req & m_gnt. The other source's gnt = 0.
- On a handshake:
  - Push the source tag (SRC_I/SRC_D) into the FIFO.
  - Update last_grant to the granted source.
- On m_rvalid with the FIFO non-empty:
  - Pop the head.
  - Assert i_rvalid or d_rvalid according to the tag, in the same cycle (combinational from m_rvalid).
  - i_rdata = d_rdata = m_rdata.
- Simultaneous handshake and m_rvalid: push and pop both occur; the count is unchanged.
- m_rvalid with the FIFO empty is a protocol violation:
  - Set err = 1, sticky until rst.
  - Drop the response; neither rvalid asserts.
- Wrap-around: FIFO pointers are log2(MAX_OUTSTANDING) bits wide and wrap naturally. The count is log2(MAX_OUTSTANDING)+1 bits wide.
- Requesters hold req and payload stable until gnt. A requester dropping req before gnt is legal; nothing is recorded.
- Reset mid-operation:
  - All outstanding tags are discarded.
  - The memory side must be reset in the same cycle.
  - A stale m_rvalid after reset sets err.

Decomposition:
- Shared package types: add src_e {SRC_I=1'b0, SRC_D=1'b1}.
- Reuse existing u32_t and wrstb_t.
- Sub-module tag_fifo:
  - Parameters: DEPTH, WIDTH=1.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Same clk and rst.
- Arbitration and muxing stay in the top level.

Test Plan:
- Reset, then i_req=1 at addr 0x0000_0010, m_gnt=1, m_rvalid two cycles later with rdata 0xDEAD_BEEF -> i_gnt=1 in cycle 0; i_rvalid=1 with i_rdata=0xDEAD_BEEF two cycles later; d_rvalid stays 0.
- DATA_PRIORITY=0, i_req and d_req held high, m_gnt=1, responses every cycle -> grants alternate I,D,I,D starting with I; rvalid routing matches the order.
- DATA_PRIORITY=1, both requesting for 4 cycles -> d_gnt=1 every cycle, i_gnt=0 throughout.
- MAX_OUTSTANDING=2, m_gnt=1, no m_rvalid -> exactly 2 handshakes, then m_req=0. m_rvalid arrives while full and i_req is still high -> m_req stays 0 that cycle and rises next cycle.
- Store d_wrstb=4'b0011, d_wrdata=0x1234_5678, m_gnt low for 3 cycles -> m_req held with a stable payload, d_gnt=0 until m_gnt; the store's response asserts d_rvalid.
- Idle, m_rvalid pulsed -> err=1 next cycle and stays high; only rst clears it.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: 32-bit words, write strobes,
// requester source tag and the forwarded memory request payload.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STRB_W  = 4;

  typedef logic [WORD_W-1:0] u32_t;
  typedef logic [STRB_W-1:0] wrstb_t;

  // Requester that owns an in-flight access
  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  // Request payload forwarded to the memory port
  typedef struct packed {
    u32_t   addr;
    u32_t   wrdata;
    wrstb_t wrstb;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// Source-tag FIFO: remembers which requester owns each in-flight access so
// in-order responses can be routed back.
// Ports: clk, rst (async, active-high), push/wdata (enqueue), pop/rdata
// (dequeue head, rdata shows head), full, empty, count (occupancy).
module tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  // Wrap at DEPTH-1; identical to natural wrap for power-of-two DEPTH > 1
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Tag storage; contents are meaningless while the matching count is zero
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU instruction (I) and data (D) request ports onto one
// memory request port, tracks in-flight ownership and routes responses back.
// Ports: clk, rst (async, active-high); I side i_req/i_addr -> i_gnt,
// i_rvalid/i_rdata; D side d_req/d_addr/d_wrdata/d_wrstb -> d_gnt,
// d_rvalid/d_rdata; memory side m_req/m_addr/m_wrdata/m_wrstb, m_gnt,
// m_rvalid/m_rdata; err is a sticky flag for a response with nothing pending.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          DATA_PRIORITY   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req,
  input  logic [31:0]  i_addr,
  output logic         i_gnt,
  output logic         i_rvalid,
  output logic [31:0]  i_rdata,
  input  logic         d_req,
  input  logic [31:0]  d_addr,
  input  logic [31:0]  d_wrdata,
  input  logic [3:0]   d_wrstb,
  output logic         d_gnt,
  output logic         d_rvalid,
  output logic [31:0]  d_rdata,
  output logic         m_req,
  output logic [31:0]  m_addr,
  output logic [31:0]  m_wrdata,
  output logic [3:0]   m_wrstb,
  input  logic         m_gnt,
  input  logic         m_rvalid,
  input  logic [31:0]  m_rdata,
  output logic         err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  src_e       sel;
  src_e       last_grant;
  src_e       head_src;
  mem_req_t   req_pl;
  logic       full;
  logic       empty;
  logic       hs;
  logic       pop;
  logic       head_tag;
  logic [CNT_W-1:0] outstanding_unused;

  // Requester selection and payload mux, same cycle as the request
  always_comb begin
    sel    = SRC_I;
    req_pl = '0;
    if (i_req && d_req) begin
      if (DATA_PRIORITY) sel = SRC_D;
      else               sel = (last_grant == SRC_D) ? SRC_I : SRC_D;
    end else if (d_req) begin
      sel = SRC_D;
    end
    if (sel == SRC_D) begin
      req_pl.addr   = d_addr;
      req_pl.wrdata = d_wrdata;
      req_pl.wrstb  = d_wrstb;
    end else begin
      req_pl.addr   = i_addr;
    end
  end

  // No bypass: a retirement in a full cycle does not free a slot until next cycle
  assign m_req    = (i_req | d_req) & ~full;
  assign m_addr   = req_pl.addr;
  assign m_wrdata = req_pl.wrdata;
  assign m_wrstb  = req_pl.wrstb;

  assign hs    = m_req & m_gnt;
  assign i_gnt = hs & (sel == SRC_I);
  assign d_gnt = hs & (sel == SRC_D);

  // Responses arrive in request order, so the FIFO head names the owner
  assign pop      = m_rvalid & ~empty;
  assign head_src = src_e'(head_tag);
  assign i_rvalid = pop & (head_src == SRC_I);
  assign d_rvalid = pop & (head_src == SRC_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .pop   (pop),
    .wdata (1'(sel)),
    .rdata (head_tag),
    .full  (full),
    .empty (empty),
    .count (outstanding_unused)
  );

  // Round-robin history and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= SRC_D;
      err        <= 1'b0;
    end else begin
      if (hs) last_grant <= sel;
      if (m_rvalid && empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (dut) and a
// data-priority instance (dut_p) share the same stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wrdata;
  logic [3:0]  d_wrstb;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wrdata;
  logic [3:0]  m_wrstb;

  logic        p_i_gnt, p_i_rvalid, p_d_gnt, p_d_rvalid, p_m_req, p_err;
  logic [31:0] p_i_rdata, p_d_rdata, p_m_addr, p_m_wrdata;
  logic [3:0]  p_m_wrstb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wrdata(d_wrdata), .d_wrstb(d_wrstb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wrdata(m_wrdata), .m_wrstb(m_wrstb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b1)) dut_p (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(p_i_gnt), .i_rvalid(p_i_rvalid), .i_rdata(p_i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wrdata(d_wrdata), .d_wrstb(d_wrstb),
    .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
    .m_req(p_m_req), .m_addr(p_m_addr), .m_wrdata(p_m_wrdata), .m_wrstb(p_m_wrstb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(p_err)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wrdata = '0; d_wrstb = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, err});
    end
    tick();
    rst = 1'b0;
    // First grant after reset on a tie must go to I
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0004; d_addr = 32'h0000_0008;
    @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, m_req} !== 3'b001 || m_addr !== 32'h0000_0004) begin
      errors++;
      $display("FAIL reset_first_tie: got gnt_i/d/mreq=%b addr=%h expected 001 addr=00000004",
               {i_gnt, d_gnt, m_req}, m_addr);
    end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0010; m_gnt = 1'b1;
    d_wrdata = 32'hFFFF_FFFF; d_wrstb = 4'hF;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt: i_gnt=%b d_gnt=%b expected 1 0", i_gnt, d_gnt);
    end
    checks++;
    if (m_addr !== 32'h0000_0010 || m_wrstb !== 4'h0 || m_wrdata !== 32'h0) begin
      errors++;
      $display("FAIL single_payload: addr=%h strb=%h data=%h expected 00000010 0 00000000",
               m_addr, m_wrstb, m_wrdata);
    end
    tick();
    i_req = 1'b0; m_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || i_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_gap: m_req=%b i_rvalid=%b expected 0 0", m_req, i_rvalid);
    end
    tick();
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: i_rvalid=%b i_rdata=%h d_rvalid=%b expected 1 deadbeef 0",
               i_rvalid, i_rdata, d_rvalid);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL single_err: err=%b expected 0", err);
    end
    tick();
  endtask

  task automatic test_round_robin();
    bit exp_i [4];
    exp_i = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
    m_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      m_rvalid = (c > 0);
      m_rdata  = 32'hA000_0000 + 32'(c);
      @(negedge clk);
      checks++;
      if (i_gnt !== exp_i[c] || d_gnt !== !exp_i[c] ||
          m_addr !== (exp_i[c] ? 32'h0000_0100 : 32'h0000_0200)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: i_gnt=%b d_gnt=%b addr=%h expected i_gnt=%b",
                 c, i_gnt, d_gnt, m_addr, exp_i[c]);
      end
      if (c > 0) begin
        checks++;
        if (i_rvalid !== exp_i[c-1] || d_rvalid !== !exp_i[c-1] ||
            i_rdata !== 32'hA000_0000 + 32'(c)) begin
          errors++;
          $display("FAIL rr_route[%0d]: i_rvalid=%b d_rvalid=%b rdata=%h expected i_rvalid=%b",
                   c, i_rvalid, d_rvalid, i_rdata, exp_i[c-1]);
        end
      end
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_00D4;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 32'h0000_00D4 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: d_rvalid=%b i_rvalid=%b d_rdata=%h m_req=%b expected 1 0 000000d4 0",
               d_rvalid, i_rvalid, d_rdata, m_req);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rr_err: err=%b expected 0", err);
    end
    tick();
  endtask

  task automatic test_data_priority();
    do_reset();
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0300; d_addr = 32'h0000_0400;
    d_wrdata = 32'hCAFE_F00D; d_wrstb = 4'hF; m_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      m_rvalid = (c > 0);
      m_rdata  = 32'hB000_0000 + 32'(c);
      @(negedge clk);
      checks++;
      if (p_d_gnt !== 1'b1 || p_i_gnt !== 1'b0 || p_m_req !== 1'b1 ||
          p_m_addr !== 32'h0000_0400 || p_m_wrdata !== 32'hCAFE_F00D || p_m_wrstb !== 4'hF) begin
        errors++;
        $display("FAIL prio_grant[%0d]: d_gnt=%b i_gnt=%b addr=%h data=%h strb=%h expected 1 0 00000400 cafef00d f",
                 c, p_d_gnt, p_i_gnt, p_m_addr, p_m_wrdata, p_m_wrstb);
      end
      if (c > 0) begin
        checks++;
        if (p_d_rvalid !== 1'b1 || p_i_rvalid !== 1'b0 ||
            p_d_rdata !== 32'hB000_0000 + 32'(c) || p_i_rdata !== 32'hB000_0000 + 32'(c)) begin
          errors++;
          $display("FAIL prio_route[%0d]: d_rvalid=%b i_rvalid=%b d_rdata=%h expected 1 0 %h",
                   c, p_d_rvalid, p_i_rvalid, p_d_rdata, 32'hB000_0000 + 32'(c));
        end
      end
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (p_err !== 1'b0) begin
      errors++;
      $display("FAIL prio_err: err=%b expected 0", p_err);
    end
    tick();
  endtask

  task automatic test_full();
    bit exp_req [5];
    bit exp_rv  [5];
    exp_req = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_rv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0500; m_gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      m_rvalid = (c == 3);
      m_rdata  = 32'h5555_0000 + 32'(c);
      @(negedge clk);
      checks++;
      if (m_req !== exp_req[c] || i_gnt !== exp_req[c] || i_rvalid !== exp_rv[c]) begin
        errors++;
        $display("FAIL full[%0d]: m_req=%b i_gnt=%b i_rvalid=%b expected %b %b %b",
                 c, m_req, i_gnt, i_rvalid, exp_req[c], exp_req[c], exp_rv[c]);
      end
      tick();
    end
    i_req = 1'b0; m_rvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL full_drain[%0d]: i_rvalid=%b d_rvalid=%b expected 1 0", c, i_rvalid, d_rvalid);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL full_err: err=%b expected 0", err);
    end
    tick();
  endtask

  task automatic test_store_stall();
    do_reset();
    d_req = 1'b1; d_addr = 32'h0000_0040; d_wrdata = 32'h1234_5678; d_wrstb = 4'b0011;
    m_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_req !== 1'b1 || d_gnt !== 1'b0 || m_addr !== 32'h0000_0040 ||
          m_wrdata !== 32'h1234_5678 || m_wrstb !== 4'b0011) begin
        errors++;
        $display("FAIL stall[%0d]: m_req=%b d_gnt=%b addr=%h data=%h strb=%b expected 1 0 00000040 12345678 0011",
                 c, m_req, d_gnt, m_addr, m_wrdata, m_wrstb);
      end
      tick();
    end
    m_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
      errors++;
      $display("FAIL stall_gnt: d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt);
    end
    tick();
    d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL stall_resp: d_rvalid=%b i_rvalid=%b expected 1 0", d_rvalid, i_rvalid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_spurious_rvalid();
    do_reset();
    m_rvalid = 1'b1; m_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL spur_drop: i_rvalid=%b d_rvalid=%b err=%b expected 0 0 0", i_rvalid, d_rvalid, err);
    end
    tick();
    m_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL spur_sticky[%0d]: err=%b expected 1", c, err);
      end
      tick();
    end
    // Sticky error survives normal traffic; only reset clears it
    i_req = 1'b1; m_gnt = 1'b1;
    tick();
    i_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL spur_traffic: i_rvalid=%b err=%b expected 1 1", i_rvalid, err);
    end
    tick();
    do_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL spur_clear: err=%b expected 0", err);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_data_priority();
    test_full();
    test_store_stall();
    test_spurious_rvalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
